// File: rtl/hazard_forward_unit.sv
// Decode-stage hazard detector and forward-select generator.
// It remembers the destinations of the three instructions ahead of ID
// (entering EX, in MEM, in WB). For each ID source operand it registers a
// select code for the EX operand mux. It also raises a one-cycle stall when
// the ID instruction reads the result of a load that is just entering EX.
module hazard_forward_unit #(
  parameter int REG_W  = 6,
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_id,
  input  logic [REG_W-1:0]  rs1_id,
  input  logic [REG_W-1:0]  rs2_id,
  input  logic              use_rs1,
  input  logic              use_rs2,
  input  logic [REG_W-1:0]  rd_id,
  input  logic              reg_write_id,
  input  logic              mem_read_id,
  input  logic              flush,
  output logic [CODE_W-1:0] forward_data,
  output logic [CODE_W-1:0] forward_data2,
  output logic              stall
);

  // Forward-mux select encodings. 010 and 100 are deliberately unused.
  localparam logic [CODE_W-1:0] SEL_RF      = CODE_W'(3'b000);
  localparam logic [CODE_W-1:0] SEL_EXE     = CODE_W'(3'b001);
  localparam logic [CODE_W-1:0] SEL_MEM_ALU = CODE_W'(3'b011);
  localparam logic [CODE_W-1:0] SEL_MEM_MEM = CODE_W'(3'b101);
  localparam logic [CODE_W-1:0] SEL_WB      = CODE_W'(3'b110);
  localparam logic [CODE_W-1:0] SEL_BUBBLE  = CODE_W'(3'b111);

  typedef enum logic {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

  state_t state_reg;

  // Tracker entries: index 0 = E1 (entering EX), 1 = E2 (MEM), 2 = E3 (WB).
  logic             ent_valid_reg [3];
  logic [REG_W-1:0] ent_rd_reg    [3];
  logic             ent_wr_reg    [3];
  // Only E1 and E2 need the load flag. A load in WB forwards the same way
  // as an ALU result.
  logic             ent_ld_reg    [2];

  logic [CODE_W-1:0] fwd_data_reg;
  logic [CODE_W-1:0] fwd_data2_reg;

  // Per-operand views of the ID sources so that both operands share one
  // generate body.
  logic [REG_W-1:0]  src       [2];
  logic              src_use   [2];
  logic              load_use_op [2];
  logic [CODE_W-1:0] fwd_next  [2];

  assign src[0]     = rs1_id;
  assign src[1]     = rs2_id;
  assign src_use[0] = use_rs1;
  assign src_use[1] = use_rs2;

  // Load-use stall is only raised in RUN. A flush kills the instruction, so
  // there is nothing to wait for. The stall is also held low during reset.
  assign stall = reset_n & (state_reg == ST_RUN) & valid_id & ~flush &
                 (load_use_op[0] | load_use_op[1]);

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_op
    logic [2:0]        hit;
    logic [CODE_W-1:0] op_code;

    // Compare this source against every valid, writing tracker entry.
    // x0 is hard-wired zero, so it never matches.
    always_comb begin
      hit = '0;
      for (int k = 0; k < 3; k++) begin
        hit[k] = ent_valid_reg[k] & ent_wr_reg[k] &
                 (ent_rd_reg[k] == src[gi]) & (src[gi] != '0) & src_use[gi];
      end
    end

    assign load_use_op[gi] = hit[0] & ent_ld_reg[0];

    // The youngest producer wins. A load still in E1 cannot forward yet,
    // so that case becomes a bubble.
    always_comb begin
      op_code = SEL_RF;
      if (hit[0])      op_code = ent_ld_reg[0] ? SEL_BUBBLE : SEL_EXE;
      else if (hit[1]) op_code = ent_ld_reg[1] ? SEL_MEM_MEM : SEL_MEM_ALU;
      else if (hit[2]) op_code = SEL_WB;
    end

    // Flush and load-use both turn the EX instruction into a bubble.
    // An empty ID slot uses the register file value.
    always_comb begin
      fwd_next[gi] = op_code;
      if (flush | stall) fwd_next[gi] = SEL_BUBBLE;
      else if (!valid_id) fwd_next[gi] = SEL_RF;
    end
  end

  // Advance the tracker and register the selects once per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) begin
        ent_valid_reg[k] <= 1'b0;
        ent_rd_reg[k]    <= '0;
        ent_wr_reg[k]    <= 1'b0;
      end
      ent_ld_reg[0] <= 1'b0;
      ent_ld_reg[1] <= 1'b0;
      fwd_data_reg  <= SEL_RF;
      fwd_data2_reg <= SEL_RF;
    end else begin
      ent_valid_reg[2] <= ent_valid_reg[1];
      ent_rd_reg[2]    <= ent_rd_reg[1];
      ent_wr_reg[2]    <= ent_wr_reg[1];
      ent_valid_reg[1] <= ent_valid_reg[0];
      ent_rd_reg[1]    <= ent_rd_reg[0];
      ent_wr_reg[1]    <= ent_wr_reg[0];
      ent_ld_reg[1]    <= ent_ld_reg[0];
      ent_valid_reg[0] <= valid_id & ~stall & ~flush;
      ent_rd_reg[0]    <= rd_id;
      ent_wr_reg[0]    <= reg_write_id;
      ent_ld_reg[0]    <= mem_read_id;
      fwd_data_reg     <= fwd_next[0];
      fwd_data2_reg    <= fwd_next[1];
    end
  end

  // STALL lasts exactly one cycle; a flush always returns to RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_RUN;
    end else begin
      case (state_reg)
        ST_RUN:   state_reg <= (stall & ~flush) ? ST_STALL : ST_RUN;
        ST_STALL: state_reg <= ST_RUN;
        default:  state_reg <= ST_RUN;
      endcase
    end
  end

  assign forward_data  = fwd_data_reg;
  assign forward_data2 = fwd_data2_reg;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit. A history model of the
// instructions issued into EX predicts the select codes and the stall.
// Literal expectations on chosen vectors pin the model itself.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       valid_id = 1'b0;
  logic [5:0] rs1_id = '0;
  logic [5:0] rs2_id = '0;
  logic       use_rs1 = 1'b0;
  logic       use_rs2 = 1'b0;
  logic [5:0] rd_id = '0;
  logic       reg_write_id = 1'b0;
  logic       mem_read_id = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] forward_data;
  logic [2:0] forward_data2;
  logic       stall;

  hazard_forward_unit #(.REG_W(6), .CODE_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .valid_id(valid_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .rd_id(rd_id), .reg_write_id(reg_write_id), .mem_read_id(mem_read_id),
    .flush(flush), .forward_data(forward_data), .forward_data2(forward_data2),
    .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; int rd; bit wr; bit ld; } ins_t;

  // hist[0] is the youngest instruction issued into EX.
  ins_t hist [3];
  bit   prev_stalled;
  int   exp_f1, exp_f2;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) hist[k] = '{v: 0, rd: 0, wr: 0, ld: 0};
    prev_stalled = 0;
    exp_f1 = 0;
    exp_f2 = 0;
  endtask

  // Select code for one source: find the age of the youngest older writer.
  function automatic int model_code(input int s, input bit u);
    if (!u || s == 0) return 0;
    for (int age = 0; age < 3; age++) begin
      if (hist[age].v && hist[age].wr && hist[age].rd == s) begin
        if (age == 0) return hist[age].ld ? 7 : 1;
        if (age == 1) return hist[age].ld ? 5 : 3;
        return 6;
      end
    end
    return 0;
  endfunction

  // One ID cycle. The e_* arguments are literal expectations; -1 skips them.
  task automatic step(input bit v, input int r1, input int r2, input bit u1,
                      input bit u2, input int rd, input bit wr, input bit ld,
                      input bit fl, input int e_f1, input int e_f2,
                      input int e_st);
    int  c1, c2;
    bit  exp_stall;
    @(negedge clk);
    valid_id = v; rs1_id = 6'(r1); rs2_id = 6'(r2); use_rs1 = u1;
    use_rs2 = u2; rd_id = 6'(rd); reg_write_id = wr; mem_read_id = ld;
    flush = fl;
    c1 = model_code(r1, u1);
    c2 = model_code(r2, u2);
    exp_stall = v && !fl && !prev_stalled && (c1 == 7 || c2 == 7);
    #1;
    check("stall_model", int'(stall), int'(exp_stall));
    if (e_st >= 0) check("stall_literal", int'(stall), e_st);
    if (fl || exp_stall) begin
      exp_f1 = 7; exp_f2 = 7;
    end else if (!v) begin
      exp_f1 = 0; exp_f2 = 0;
    end else begin
      exp_f1 = c1; exp_f2 = c2;
    end
    @(posedge clk);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = '{v: v && !exp_stall && !fl, rd: rd, wr: wr, ld: ld};
    prev_stalled = exp_stall;
    #1;
    $display("vec v=%0d rs1=%0d rs2=%0d rd=%0d wr=%0d ld=%0d fl=%0d -> fd=%0d fd2=%0d st=%0d",
             v, r1, r2, rd, wr, ld, fl, forward_data, forward_data2, exp_stall);
    check("fwd1_model", int'(forward_data), exp_f1);
    check("fwd2_model", int'(forward_data2), exp_f2);
    if (e_f1 >= 0) check("fwd1_literal", int'(forward_data), e_f1);
    if (e_f2 >= 0) check("fwd2_literal", int'(forward_data2), e_f2);
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #1;
    check("reset_stall", int'(stall), 0);
    check("reset_fwd1", int'(forward_data), 0);
    check("reset_fwd2", int'(forward_data2), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // add x5,x1,x2 ; sub x6,x5,x7
    step(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0);
    step(1, 5, 7, 1, 1, 6, 1, 0, 0, 1, 0, 0);
    nop(); nop(); nop();

    // lw x8 ; add x9,x8,x8 (stall, then re-evaluated against MEM)
    step(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0);
    step(1, 8, 8, 1, 1, 9, 1, 0, 0, 7, 7, 1);
    step(1, 8, 8, 1, 1, 9, 1, 0, 0, 5, 5, 0);
    nop(); nop(); nop();

    // Producer x3 at distance 2, 3, 4
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    nop();
    step(1, 3, 0, 1, 0, 21, 1, 0, 0, 3, 0, 0);
    nop(); nop(); nop();
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, -1, -1, 0);
    nop(); nop();
    step(1, 0, 3, 0, 1, 21, 1, 0, 0, 0, 6, 0);
    nop(); nop(); nop();
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, -1, -1, 0);
    nop(); nop(); nop();
    step(1, 3, 3, 1, 1, 21, 1, 0, 0, 0, 0, 0);
    nop(); nop(); nop();

    // x0 never matches; wr=0 producer never matches
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, -1, -1, 0);
    step(1, 0, 0, 1, 1, 22, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 10, 0, 0, 0, -1, -1, 0);
    step(1, 10, 10, 1, 1, 23, 1, 0, 0, 0, 0, 0);
    nop(); nop(); nop();

    // E1 and E3 both write x4: youngest wins
    step(1, 0, 0, 0, 0, 4, 1, 0, 0, -1, -1, 0);
    step(1, 0, 0, 0, 0, 11, 1, 0, 0, -1, -1, 0);
    step(1, 0, 0, 0, 0, 4, 1, 0, 0, -1, -1, 0);
    step(1, 4, 4, 1, 1, 24, 1, 0, 0, 1, 1, 0);
    nop(); nop(); nop();

    // Independent operands: rs1 from EX (001), rs2 from WB (110)
    step(1, 0, 0, 0, 0, 13, 1, 0, 0, -1, -1, 0);
    step(1, 0, 0, 0, 0, 20, 1, 0, 0, -1, -1, 0);
    step(1, 0, 0, 0, 0, 12, 1, 0, 0, -1, -1, 0);
    step(1, 12, 13, 1, 1, 25, 1, 0, 0, 1, 6, 0);
    nop(); nop(); nop();

    // Load-use on rs2 only
    step(1, 0, 0, 0, 0, 17, 1, 1, 0, -1, -1, 0);
    step(1, 1, 17, 1, 1, 26, 1, 0, 0, 7, 7, 1);
    step(1, 1, 17, 1, 1, 26, 1, 0, 0, 0, 5, 0);
    nop(); nop(); nop();

    // Flush coincident with load-use: bubble, no stall
    step(1, 0, 0, 0, 0, 15, 1, 1, 0, -1, -1, 0);
    step(1, 15, 0, 1, 0, 27, 1, 0, 1, 7, 7, 0);
    step(1, 15, 0, 1, 0, 27, 1, 0, 0, 5, 0, 0);
    nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    nop(); nop(); nop();

    // Reset asserted during STALL: codes clear without a clock edge
    step(1, 0, 0, 0, 0, 16, 1, 1, 0, -1, -1, 0);
    step(1, 16, 16, 1, 1, 28, 1, 0, 0, 7, 7, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async_rst_fwd1", int'(forward_data), 0);
    check("async_rst_fwd2", int'(forward_data2), 0);
    check("async_rst_stall", int'(stall), 0);
    $display("vec async reset mid-stall -> fd=%0d fd2=%0d st=%0d",
             forward_data, forward_data2, stall);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 16, 16, 1, 1, 28, 1, 0, 0, 0, 0, 0);
    step(1, 28, 0, 1, 0, 29, 1, 0, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
